elementwise_mul_ctrl: RTL and testbench
=======================================

# elementwise_mul_ctrl

Sequencer and two-port arbiter for the 4x4 int8 elementwise multiplier (`elementwise_mul`).
- Accepts matrix-pair jobs from two requesters over valid/ready and grants one at a time with round-robin.
- Drives the multiplier operands, waits out its pipeline latency, and returns the 128-bit product tagged with the requester ID.
- Sits between the unified datapath's operand sources and the shared multiplier instance; it is the only driver of the multiplier inputs.

## Interface
Parameters:
- `MUL_LAT`, 1: register stages in `elementwise_mul`, counted from operands stable at a posedge to `mul_m` valid. Legal range 1..15.
- `DATA_W`, 128: packed matrix width, 16 elements × 8 bit, element k at `[8k+7:8k]`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a job.
- `req0_ready`  out  1  requester 0 job accepted this cycle.
- `req0_u`, `req0_v`  in  DATA_W  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_u`, `req1_v`: same as requester 0, for requester 1.
- `mul_u`, `mul_v`  out  DATA_W  operands to `elementwise_mul` `U_entry` / `V_entry`.
- `mul_m`  in  DATA_W  product from `elementwise_mul` `M`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_m`  out  DATA_W  product matrix.
- `res_id`  out  1  requester index of the result.
- `busy`  out  1  high in every state except IDLE.
- `perf_jobs`  out  16  completed-job count. Present only with `ELEMWISE_CTRL_PERF_EN`.

## Operation
State machine IDLE → WAIT → DONE → IDLE.

- **IDLE**
  - `mul_u` and `mul_v` are held at 0 (multiplier quiet).
  - Grant rule: if exactly one `reqN_valid` is high, grant N. If both are high, grant the requester that was not granted last.
  - `reqN_ready` is combinational, `= (state==IDLE) & grant==N`. At most one ready is high per cycle.
  - On handshake, operands are registered into `mul_u`/`mul_v`, the ID is registered, `cnt` is loaded with `MUL_LAT`, and the state moves to WAIT.
- **WAIT**
  - Operands are held stable.
  - While `cnt!=0`, `cnt` decrements each cycle.
  - When `cnt==0`: `res_m <= mul_m`, `res_id <=` registered ID, `res_valid <= 1`, `mul_u`/`mul_v` `<= 0`, and the state moves to DONE.
- **DONE**
  - `res_m`, `res_id` and `res_valid` are held until `res_valid & res_ready`.
  - On that handshake: `res_valid <= 0`, the round-robin pointer records the served ID, and the state moves to IDLE.
- **Datapath**: the controller does no arithmetic. Element truncation/width is owned by `elementwise_mul`; `res_m` is a bit-exact copy of `mul_m`.
- **Request rules**
  - A requester may drop `valid` before it is granted; no job is recorded.
  - Operand values are sampled only on the handshake edge.

## Timing
- **Reset values**: every output is 0. The round-robin pointer favours requester 0 on the first contention.
- **Latency**: with the accept edge as E0, `res_valid` is first high in the cycle after edge E0+MUL_LAT+1. With `MUL_LAT=1`, that is 2 cycles after accept.
- **Throughput**:
  - Minimum job period is MUL_LAT+3 cycles with `res_ready` tied high.
  - There is no overlap: a new accept can happen only in IDLE, at the earliest the cycle after the result handshake.
- **Back-pressure**: DONE persists indefinitely while `res_ready=0`, and both `reqN_ready` stay low.
- **Reset mid-operation**: a synchronous `rst` in WAIT or DONE discards the job. No result is produced, and all outputs are 0 on the next cycle.
- **Simultaneous events**: a request arriving in the same cycle as the result handshake is not accepted until the following (IDLE) cycle.

## Configuration
- **`ELEMWISE_CTRL_PERF_EN` defined**:
  - The `perf_jobs` port and counter exist.
  - The counter increments on every result handshake, wraps 0xFFFF→0, and resets to 0.
- **`ELEMWISE_CTRL_PERF_EN` undefined**: the port and counter are absent. All other behaviour is identical.

## Structure
- **Shared package `elementwise_pkg`**:
  - `ELEM_W=8`, `N_ELEM=16`, `DATA_W=ELEM_W*N_ELEM`.
  - State enum `ew_state_t` {IDLE, WAIT, DONE}.
  - `CNT_W=4`.
- **Sub-module `rr_arb2`**:
  - Two-input round-robin arbiter.
  - Inputs: valids, last-grant pointer. Outputs: one-hot grant, grant index.
  - Combinational; the pointer register lives in the controller.

## Test plan
- **Single job**: req0 with U=V elements 1..16 after `rst` release, `res_ready=1` → `res_valid` 2 cycles after accept (`MUL_LAT=1`), `res_m` elements = 1,4,9,…,256 truncated per `elementwise_mul`, `res_id=0`, `mul_u`/`mul_v` return to 0.
- **Contention**: req0 and req1 both valid continuously for 4 jobs → grants alternate 0,1,0,1. Exactly one ready per accept, and the `res_id` sequence matches.
- **Back-pressure**: `res_ready=0` for 10 cycles after `res_valid` → `res_m` and `res_id` stable, both `req_ready` low, `busy=1`. Raising `res_ready` completes the handshake, and IDLE follows the next cycle.
- **Reset mid-job**: assert `rst` one cycle after accept → no `res_valid`, all outputs 0, first subsequent contention granted to req0.
- **Latency parameter**: `MUL_LAT=3` with a 3-stage multiplier model → `res_valid` 4 cycles after accept, operands held through WAIT.
- **Perf counter**: with `ELEMWISE_CTRL_PERF_EN`, 5 completed jobs → `perf_jobs=5`. Preload near wrap → 0xFFFF+1 reads 0.

Source files
------------

// File: rtl/elementwise_pkg.sv
// Shared types and constants for the elementwise multiplier controller.
package elementwise_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 16;
    localparam int DATA_W = ELEM_W * N_ELEM;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } ew_state_t;

endpackage

// File: rtl/elementwise_mul_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer is held by the caller.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);
    import elementwise_pkg::*;

    always_comb begin
        gnt_idx_o = 1'b0;
        // On contention the requester not served last wins.
        if (&valid_i) begin
            gnt_idx_o = ~last_i;
        end else if (valid_i[1]) begin
            gnt_idx_o = 1'b1;
        end
        gnt_o = valid_i & (gnt_idx_o ? 2'b10 : 2'b01);
    end

endmodule

// File: rtl/elementwise_mul_ctrl.sv
// Sequencer/arbiter feeding the shared 4x4 int8 elementwise multiplier.
// Optional completed-job counter: define ELEMWISE_CTRL_PERF_EN.
module elementwise_mul_ctrl #(
    parameter int MUL_LAT = 1,
    parameter int DATA_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_u,
    input  logic [DATA_W-1:0] req0_v,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_u,
    input  logic [DATA_W-1:0] req1_v,
    output logic [DATA_W-1:0] mul_u,
    output logic [DATA_W-1:0] mul_v,
    input  logic [DATA_W-1:0] mul_m,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_m,
    output logic              res_id,
`ifdef ELEMWISE_CTRL_PERF_EN
    output logic              busy,
    output logic [15:0]       perf_jobs
`else
    output logic              busy
`endif
);
    import elementwise_pkg::*;

    ew_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mu_q, mu_d, mv_q, mv_d, rm_q, rm_d;
    logic              id_q, id_d, rid_q, rid_d, rv_q, rv_d, last_q, last_d;
    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              acc;
    logic              res_hs;

    rr_arb2 u_arb (
        .valid_i   ({req1_valid, req0_valid}),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Grants are already qualified by valid, so ready implies a handshake.
    assign req0_ready = (state_q == IDLE) & gnt[0];
    assign req1_ready = (state_q == IDLE) & gnt[1];
    assign acc        = req0_ready | req1_ready;
    assign res_hs     = rv_q & res_ready;

    assign mul_u     = mu_q;
    assign mul_v     = mv_q;
    assign res_m     = rm_q;
    assign res_id    = rid_q;
    assign res_valid = rv_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mu_d    = mu_q;
        mv_d    = mv_q;
        id_d    = id_q;
        rm_d    = rm_q;
        rid_d   = rid_q;
        rv_d    = rv_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    mu_d    = gnt_idx ? req1_u : req0_u;
                    mv_d    = gnt_idx ? req1_v : req0_v;
                    id_d    = gnt_idx;
                    cnt_d   = CNT_W'(MUL_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rm_d    = mul_m;
                    rid_d   = id_q;
                    rv_d    = 1'b1;
                    mu_d    = '0;
                    mv_d    = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_hs) begin
                    rv_d    = 1'b0;
                    last_d  = rid_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mu_q    <= '0;
            mv_q    <= '0;
            id_q    <= 1'b0;
            rm_q    <= '0;
            rid_q   <= 1'b0;
            rv_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mu_q    <= mu_d;
            mv_q    <= mv_d;
            id_q    <= id_d;
            rm_q    <= rm_d;
            rid_q   <= rid_d;
            rv_q    <= rv_d;
            last_q  <= last_d;
        end
    end

`ifdef ELEMWISE_CTRL_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (res_hs) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_jobs = perf_q;
`endif

endmodule

// File: tb/tb_elementwise_mul_ctrl.sv
// Randomized + directed bench for elementwise_mul_ctrl with a time-based job model.
module tb_elementwise_mul_ctrl;
    localparam int DW = 128;
    localparam int L  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0_valid, req1_valid, res_ready;
    logic [DW-1:0] req0_u, req0_v, req1_u, req1_v;
    logic          req0_ready, req1_ready, res_valid, res_id, busy;
    logic [DW-1:0] mul_u, mul_v, mul_m, res_m;

    logic          d3_valid, d3_ready, d3_r1ready, d3_res_valid, d3_res_ready, d3_res_id, d3_busy;
    logic [DW-1:0] d3_u, d3_v, d3_mul_u, d3_mul_v, d3_mul_m, d3_res_m;
    logic [DW-1:0] s3a, s3b;
`ifdef ELEMWISE_CTRL_PERF_EN
    logic [15:0]   perf_jobs, d3_perf;
`endif

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    function automatic logic [DW-1:0] mulf(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [15:0]   p;
        for (int k = 0; k < 16; k++) begin
            p = a[8*k +: 8] * b[8*k +: 8];
            r[8*k +: 8] = p[7:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    elementwise_mul_ctrl #(.MUL_LAT(L), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_u(req0_u), .req0_v(req0_v),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_u(req1_u), .req1_v(req1_v),
        .mul_u(mul_u), .mul_v(mul_v), .mul_m(mul_m),
        .res_valid(res_valid), .res_ready(res_ready), .res_m(res_m), .res_id(res_id),
`ifdef ELEMWISE_CTRL_PERF_EN
        .perf_jobs(perf_jobs),
`endif
        .busy(busy)
    );

    elementwise_mul_ctrl #(.MUL_LAT(3), .DATA_W(DW)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(d3_valid), .req0_ready(d3_ready), .req0_u(d3_u), .req0_v(d3_v),
        .req1_valid(1'b0), .req1_ready(d3_r1ready), .req1_u('0), .req1_v('0),
        .mul_u(d3_mul_u), .mul_v(d3_mul_v), .mul_m(d3_mul_m),
        .res_valid(d3_res_valid), .res_ready(d3_res_ready), .res_m(d3_res_m), .res_id(d3_res_id),
`ifdef ELEMWISE_CTRL_PERF_EN
        .perf_jobs(d3_perf),
`endif
        .busy(d3_busy)
    );

    // Multiplier stand-ins: 1-stage and 3-stage pipelines
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mul_m    <= mulf(mul_u, mul_v);
        s3a      <= mulf(d3_mul_u, d3_mul_v);
        s3b      <= s3a;
        d3_mul_m <= s3b;
    end

    // Job model: a job accepted at edge m_a owns the multiplier until edge m_a+L+1,
    // then presents its product until the consumer takes it.
    bit            chk_en = 1'b0;
    bit            m_act  = 1'b0;
    bit            m_last = 1'b1;
    bit            m_id   = 1'b0;
    int            m_a    = 0;
    logic [DW-1:0] m_u, m_v;
    logic [15:0]   m_perf = 16'd0;

    always @(negedge clk) begin : model_chk
        bit            g, e_r0, e_r1, e_rv;
        logic [DW-1:0] e_mu, e_mv;
        if (chk_en) begin
            g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = !m_act && req0_valid && !g;
            e_r1 = !m_act && req1_valid && g;
            e_rv = m_act && (cyc >= m_a + L + 1);
            e_mu = (m_act && !e_rv) ? m_u : '0;
            e_mv = (m_act && !e_rv) ? m_v : '0;
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, m_act);
            chk("res_valid", res_valid, e_rv);
            chk("mul_u", mul_u, e_mu);
            chk("mul_v", mul_v, e_mv);
            if (e_rv) begin
                chk("res_m", res_m, mulf(m_u, m_v));
                chk("res_id", res_id, m_id);
            end
`ifdef ELEMWISE_CTRL_PERF_EN
            chk("perf_jobs", perf_jobs, m_perf);
`endif
            if (rst) begin
                m_act  = 1'b0;
                m_last = 1'b1;
                m_perf = 16'd0;
            end else if (e_r0 || e_r1) begin
                m_act = 1'b1;
                m_a   = cyc + 1;
                m_id  = g;
                m_u   = g ? req1_u : req0_u;
                m_v   = g ? req1_v : req0_v;
            end else if (e_rv && res_ready) begin
                m_act  = 1'b0;
                m_last = m_id;
                m_perf = m_perf + 16'd1;
            end
        end
    end

    task automatic wait_acc(output int t);
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) t = cyc + 1;
            tick();
        end
        if (t < 0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_res(output int t);
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if (res_valid) t = cyc;
            else tick();
        end
        if (t < 0) chk("result_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            ta, tr, n;
        bit            ids[4];
        logic [DW-1:0] bm, cm;
        bit            bid;

        rst = 1'b1; req0_valid = 0; req1_valid = 0; res_ready = 0;
        req0_u = '0; req0_v = '0; req1_u = '0; req1_v = '0;
        d3_valid = 0; d3_u = '0; d3_v = '0; d3_res_ready = 1;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {res_valid, res_id, busy, req0_ready, req1_ready}, '0);
        chk("rst_data", mul_u | mul_v | res_m, '0);

        // Single job: U=V=1..16, squares truncated to 8 bits
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) req0_u[8*k +: 8] = 8'(k + 1);
        req0_v = req0_u; req0_valid = 1; res_ready = 1;
        wait_acc(ta);
        req0_valid = 0;
        wait_res(tr);
        chk("single_lat", tr - ta, 2);
        chk("single_m", res_m, 128'h00E1C4A9_90796451_40312419_10090401);
        chk("single_id", res_id, 0);
        tick();
        @(negedge clk);
        chk("single_quiet", {busy, res_valid}, 0);
        chk("single_mul0", mul_u | mul_v, '0);

        // Contention after reset: grants alternate starting with 0
        tick();
        rst = 1; tick(); rst = 0;
        req0_u = r128(); req0_v = r128(); req1_u = r128(); req1_v = r128();
        req0_valid = 1; req1_valid = 1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin ids[n] = res_id; n++; end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        chk("cont_count", n, 4);
        chk("cont_ids", {ids[0], ids[1], ids[2], ids[3]}, 4'b0101);

        // Back-pressure on a requester-1 job
        res_ready = 0; req1_u = r128(); req1_v = r128(); req1_valid = 1;
        wait_acc(ta);
        req1_valid = 0; req0_valid = 1;
        wait_res(tr);
        bm = res_m; bid = res_id;
        chk("bp_id", bid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("bp_m", res_m, bm);
            chk("bp_ctrl", {res_id, busy, req0_ready, req1_ready}, {bid, 3'b100});
        end
        tick();
        res_ready = 1;
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("bp_idle", busy, 0);

        // Serve requester 0 so the pointer would favour 1, then reset mid-job
        tick();
        req0_valid = 1;
        wait_acc(ta);
        req0_valid = 0;
        repeat (5) tick();
        req0_valid = 1;
        wait_acc(ta);
        rst = 1; req0_valid = 0;
        tick();
        rst = 0;
        @(negedge clk);
        chk("midrst_ctrl", {res_valid, res_id, busy, req0_ready, req1_ready}, '0);
        chk("midrst_data", mul_u | mul_v | res_m, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("midrst_nores", res_valid, 0);
        end
        tick();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("midrst_grant", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0; req1_valid = 0;
        repeat (6) tick();

        // Randomized traffic, back-pressure and occasional resets
        for (int i = 0; i < 800; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 1) != 0);
            req0_u = r128(); req0_v = r128(); req1_u = r128(); req1_v = r128();
            res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; req0_valid = 0; req1_valid = 0; res_ready = 1;
        repeat (8) tick();

        // Three-stage multiplier instance
        d3_u = r128(); d3_v = r128(); d3_valid = 1;
        ta = -1;
        for (int i = 0; i < 20 && ta < 0; i++) begin
            @(negedge clk);
            if (d3_ready) ta = cyc + 1;
            tick();
        end
        d3_valid = 0;
        if (ta < 0) chk("d3_accept_timeout", 0, 1);
        tr = -1;
        cm = '0;
        for (int i = 0; i < 20 && tr < 0; i++) begin
            @(negedge clk);
            if (d3_res_valid) begin
                tr = cyc; cm = d3_res_m;
            end else begin
                chk("d3_hold_u", d3_mul_u, d3_u);
                chk("d3_hold_v", d3_mul_v, d3_v);
            end
            tick();
        end
        if (tr < 0) chk("d3_result_timeout", 0, 1);
        chk("d3_lat", tr - ta, 4);
        chk("d3_m", cm, mulf(d3_u, d3_v));
        @(negedge clk);
        chk("d3_idle", {d3_busy, d3_res_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
